// File: rtl/mult8_product_accumulator.sv
// Product accumulator behind the 8x8 multiplier array: sums a programmed
// number of 16-bit products over valid/ready and returns the total with a
// sticky overflow flag, turning the combinational multipliers into a MAC.
module mult8_product_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned PROD_W = 16;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_next;
  logic             ovf;
  logic             ovf_next;

  logic             in_ready_next;
  logic             out_valid_next;
  logic             busy_next;

  logic             xfer;
  logic [SUM_W-1:0] sum;

  // A product moves only while the registered ready is up (ACCUM only)
  assign xfer = in_valid && in_ready;
  assign sum  = {1'b0, acc} + SUM_W'(in_prod);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer && (cnt == LEN_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the next state so they register with it
  always_comb begin
    in_ready_next  = 1'b0;
    out_valid_next = 1'b0;
    busy_next      = 1'b0;
    case (state_next)
      ACCUM: begin
        in_ready_next = 1'b1;
        busy_next     = 1'b1;
      end
      DONE: begin
        out_valid_next = 1'b1;
        busy_next      = 1'b1;
      end
      default: begin
        in_ready_next  = 1'b0;
        out_valid_next = 1'b0;
        busy_next      = 1'b0;
      end
    endcase
  end

  // Datapath next values: clear on start, add on each accepted product
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    ovf_next = ovf;
    if ((state == IDLE) && start) begin
      acc_next = '0;
      cnt_next = len;
      ovf_next = 1'b0;
    end else if ((state == ACCUM) && xfer) begin
      cnt_next = cnt - LEN_W'(1);
      if (sum[ACC_W]) begin
        ovf_next = 1'b1;
        acc_next = SAT ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      end else begin
        acc_next = sum[ACC_W-1:0];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      ovf <= ovf_next;
    end
  end

  // Registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      busy      <= busy_next;
    end
  end

  // Result is the accumulator itself; it holds from DONE until the next start
  assign out_acc = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_mult8_product_accumulator.sv
// Scoreboard bench: three accumulator variants (24-bit wrap, 20-bit wrap,
// 20-bit saturate) share one stimulus stream; per-instance monitors compare
// each presented result with a plain-arithmetic reference model.
module tb_mult8_product_accumulator;

  typedef struct {
    longint acc;
    bit     ovf;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        out_ready;

  logic        rdy_d, ov_d, ovf_d, busy_d;
  logic [23:0] acc_d;
  logic        rdy_w, ov_w, ovf_w, busy_w;
  logic [19:0] acc_w;
  logic        rdy_s, ov_s, ovf_s, busy_s;
  logic [19:0] acc_s;

  int n_chk;
  int n_fail;

  res_t sb0[$];
  res_t sb1[$];
  res_t sb2[$];
  int   prods[$];

  bit     seen[3];
  longint held_acc[3];
  bit     held_ovf[3];

  mult8_product_accumulator #(.ACC_W(24), .LEN_W(8), .SAT(1'b0)) u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(rdy_d), .in_prod(in_prod),
    .out_valid(ov_d), .out_ready(out_ready), .out_acc(acc_d),
    .out_ovf(ovf_d), .busy(busy_d)
  );

  mult8_product_accumulator #(.ACC_W(20), .LEN_W(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(rdy_w), .in_prod(in_prod),
    .out_valid(ov_w), .out_ready(out_ready), .out_acc(acc_w),
    .out_ovf(ovf_w), .busy(busy_w)
  );

  mult8_product_accumulator #(.ACC_W(20), .LEN_W(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(rdy_s), .in_prod(in_prod),
    .out_valid(ov_s), .out_ready(out_ready), .out_acc(acc_s),
    .out_ovf(ovf_s), .busy(busy_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: sum the products with plain integers, then apply the width policy
  function automatic res_t model(input int accw, input bit sat);
    res_t   r;
    longint a;
    longint m;
    a     = 0;
    m     = longint'(1) << accw;
    r.ovf = 1'b0;
    foreach (prods[k]) begin
      a = a + prods[k];
      if (a >= m) begin
        r.ovf = 1'b1;
        a     = sat ? (m - 1) : (a - m);
      end
    end
    r.acc = a;
    return r;
  endfunction

  // One monitor step for instance i at the falling edge
  task automatic mon(input int i, input logic ov, input logic rdy,
                     input longint acc, input logic ovf);
    res_t e;
    bit   have;
    if (ov) begin
      chk($sformatf("in_ready_in_done[%0d]", i), longint'(rdy), 0);
      if (!seen[i]) begin
        have = 1'b0;
        case (i)
          0: if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
          1: if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
          default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result[%0d]: got acc %0d, none expected", i, acc);
        end else begin
          chk($sformatf("result_acc[%0d]", i), acc, e.acc);
          chk($sformatf("result_ovf[%0d]", i), longint'(ovf), longint'(e.ovf));
        end
        seen[i]     = 1'b1;
        held_acc[i] = acc;
        held_ovf[i] = ovf;
      end else begin
        chk($sformatf("acc_stable[%0d]", i), acc, held_acc[i]);
        chk($sformatf("ovf_stable[%0d]", i), longint'(ovf), longint'(held_ovf[i]));
      end
      if (out_ready) seen[i] = 1'b0;
    end
  endtask

  // Monitors: sample away from the rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ov_d, rdy_d, longint'(acc_d), ovf_d);
      mon(1, ov_w, rdy_w, longint'(acc_w), ovf_w);
      mon(2, ov_s, rdy_s, longint'(acc_s), ovf_s);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one run of the products in prods; expectations go to the scoreboards first
  task automatic run(input int l, input int gap, input int hold, input bit pulse_start);
    int n;
    sb0.push_back(model(24, 1'b0));
    sb1.push_back(model(20, 1'b0));
    sb2.push_back(model(20, 1'b1));
    start = 1'b1;
    len   = 8'(l);
    tick();
    start = 1'b0;
    len   = 8'($urandom_range(0, 255));
    if (l == 0) chk("zero_len_in_ready", longint'(rdy_d), 0);
    foreach (prods[k]) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_prod  = 16'(prods[k]);
      if (pulse_start && (k % 50 == 10)) start = 1'b1;
      n = 0;
      while (!rdy_d && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) chk("in_ready_timeout", 0, 1);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("out_valid_latency", longint'(ov_d), 1);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("held_valid", longint'(ov_d), 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("back_to_idle_valid", longint'(ov_d), 0);
    chk("back_to_idle_busy", longint'(busy_d), 0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", longint'(rdy_d), 0);
    chk("reset_out_valid", longint'(ov_d), 0);
    chk("reset_out_acc", longint'(acc_d), 0);
    chk("reset_out_ovf", longint'(ovf_d), 0);
    chk("reset_busy", longint'(busy_d), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-run: two of four products accepted, then reset
    start = 1'b1;
    len   = 8'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_prod  = 16'd500;
    tick();
    tick();
    in_valid = 1'b0;
    chk("midrun_busy", longint'(busy_d), 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", longint'(busy_d), 0);
    chk("midrun_rst_in_ready", longint'(rdy_d), 0);
    chk("midrun_rst_acc", longint'(acc_d), 0);
    chk("midrun_rst_valid", longint'(ov_d), 0);
    tick();
    rst_n = 1'b1;
    tick();
    prods = {7};
    run(1, 0, 0, 1'b0);
    chk("after_reset_acc", longint'(acc_d), 7);

    // Basic run with back-to-back products
    prods = {65025, 65025, 65025, 65025};
    run(4, 0, 0, 1'b0);
    chk("basic_acc", longint'(acc_d), 260100);
    chk("basic_ovf", longint'(ovf_d), 0);

    // Backpressure on both sides
    prods = {1, 2, 3};
    run(3, 2, 5, 1'b0);
    chk("bp_acc", longint'(acc_d), 6);

    // Zero length
    prods = {};
    run(0, 0, 1, 1'b0);
    chk("zero_acc", longint'(acc_d), 0);
    chk("zero_ovf", longint'(ovf_d), 0);

    // Overflow at 20 bits: 16 products fit, 17 do not
    prods = {};
    for (int k = 0; k < 16; k++) prods.push_back(65025);
    run(16, 0, 0, 1'b0);
    chk("ctrl16_wrap_acc", longint'(acc_w), 1040400);
    chk("ctrl16_wrap_ovf", longint'(ovf_w), 0);
    prods.push_back(65025);
    run(17, 0, 2, 1'b0);
    chk("ovf17_wrap_acc", longint'(acc_w), 56849);
    chk("ovf17_wrap_ovf", longint'(ovf_w), 1);
    chk("ovf17_sat_acc", longint'(acc_s), 1048575);
    chk("ovf17_sat_ovf", longint'(ovf_s), 1);
    chk("ovf17_def_acc", longint'(acc_d), 1105425);

    // Maximum count with ignored start pulses during ACCUM
    prods = {};
    for (int k = 0; k < 255; k++) prods.push_back(65025);
    run(255, 0, 0, 1'b1);
    chk("max_acc", longint'(acc_d), 16581375);
    chk("max_ovf", longint'(ovf_d), 0);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      int l;
      l     = int'($urandom_range(0, 24));
      prods = {};
      for (int k = 0; k < l; k++) begin
        if ($urandom_range(0, 3) == 0) prods.push_back(65025);
        else prods.push_back(int'($urandom_range(0, 65535)));
      end
      run(l, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), r[0]);
    end

    tick();
    tick();
    chk("sb0_drained", longint'(sb0.size()), 0);
    chk("sb1_drained", longint'(sb1.size()), 0);
    chk("sb2_drained", longint'(sb2.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
